ds_frame_controller: RTL and testbench

DS_FRAME_CONTROLLER -- requirements
Module: ds_frame_controller

---
 rtl/ds_ctrl_pkg.sv | 22 ++
 rtl/ds_geom_counter.sv | 58 +++++
 rtl/ds_frame_controller.sv | 202 ++++++++++++++++++++
 tb/tb_ds_frame_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_ctrl_pkg.sv
// ds_ctrl_pkg: shared definitions for the downscaler frame controller.
//   ds_state_e   - frame FSM states
//   FRAME_CNT_W  - width of the completed-frame counter
//   ERR_CNT_W    - width of the saturating framing-error counters
//   sat_inc      - saturating increment for the error counters
package ds_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_PAD      = 2'd3
  } ds_state_e;

  localparam int FRAME_CNT_W = 16;
  localparam int ERR_CNT_W   = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ds_geom_counter.sv
// ds_geom_counter: column/line position of the next beat within a frame.
// Ports:
//   clk_i, rst_n_i        - clock, async active-low reset
//   load_i                - latch width_i/height_i; while high the end flags
//                           are computed from the live inputs
//   adv_i                 - advance one beat (col wraps to 0 with line+1,
//                           line wraps to 0 after the last line)
//   width_i, height_i     - frame geometry
//   col_end_o, line_end_o - current position is last column / last line
//   origin_o              - current position is col 0, line 0
module ds_geom_counter #(
  parameter int G_WIDTH = 12
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               adv_i,
  input  logic [G_WIDTH-1:0] width_i,
  input  logic [G_WIDTH-1:0] height_i,
  output logic               col_end_o,
  output logic               line_end_o,
  output logic               origin_o
);

  logic [G_WIDTH-1:0] col_q, line_q, w_q, h_q;
  logic [G_WIDTH-1:0] w_eff, h_eff;

  assign w_eff      = load_i ? width_i  : w_q;
  assign h_eff      = load_i ? height_i : h_q;
  assign col_end_o  = (col_q  == w_eff - G_WIDTH'(1));
  assign line_end_o = (line_q == h_eff - G_WIDTH'(1));
  assign origin_o   = (col_q == '0) && (line_q == '0);

  // The position wraps back to 0,0 on the last beat of a frame, so the
  // counter is already at the origin when the next SOF arrives.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col_q  <= '0;
      line_q <= '0;
      w_q    <= '0;
      h_q    <= '0;
    end else begin
      if (load_i) begin
        w_q <= width_i;
        h_q <= height_i;
      end
      if (adv_i) begin
        if (col_end_o) begin
          col_q  <= '0;
          line_q <= line_end_o ? '0 : line_q + G_WIDTH'(1);
        end else begin
          col_q <= col_q + G_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ds_frame_controller.sv
// ds_frame_controller: registered stream stage in front of the downscaler
// that enforces frame geometry, regenerates tuser/tlast and pads short frames.
// Ports:
//   clk, rst                        - clock, async active-low reset
//   up_*                            - upstream stream (data/valid/tlast/tuser, ready out)
//   down_*                          - downstream stream (data/valid/tlast/tuser, ready in)
//   enable                          - run request (level)
//   cfg_width, cfg_height           - pixels per line / lines per frame (even, >=2)
//   busy                            - frame in progress (ACTIVE or PAD)
//   frame_done                      - one-cycle pulse per completed frame
//   cfg_err                         - enable requested with invalid geometry
//   frame_cnt, err_sof_cnt, err_eol_cnt - status counters
// Build option: DS_FRAME_CTRL_STATUS_EN implements the status counters;
// without it they read 0 and framing behaviour is unchanged.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | not running; input beats drained and dropped
// WAIT_SOF | dropping beats until one with tuser=1 starts a frame
// ACTIVE   | forwarding pixels, tracking column/line
// PAD      | early SOF seen; emitting zero beats to finish the frame
module ds_frame_controller
  import ds_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int G_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_WIDTH-1:0]     up_data,
  input  logic                   up_valid,
  input  logic                   up_tlast,
  input  logic                   up_tuser,
  output logic                   up_ready,
  output logic [D_WIDTH-1:0]     down_data,
  output logic                   down_valid,
  output logic                   down_tlast,
  output logic                   down_tuser,
  input  logic                   down_ready,
  input  logic                   enable,
  input  logic [G_WIDTH-1:0]     cfg_width,
  input  logic [G_WIDTH-1:0]     cfg_height,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   cfg_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [ERR_CNT_W-1:0]   err_sof_cnt,
  output logic [ERR_CNT_W-1:0]   err_eol_cnt
);

  ds_state_e          state_q, state_d;
  logic               rdy_en_q;
  logic [D_WIDTH-1:0] dd_q;
  logic               dv_q, dl_q, du_q, fd_q, cfg_err_q;

  logic               pass_ok, cfg_ok, up_ready_c;
  logic               load, adv, geo_load, frame_end, sof_err, eol_err;
  logic [D_WIDTH-1:0] load_data;
  logic               col_end, line_end, origin;

  assign pass_ok = !dv_q || down_ready;
  assign cfg_ok  = !cfg_width[0] && !cfg_height[0] &&
                   (cfg_width >= G_WIDTH'(2)) && (cfg_height >= G_WIDTH'(2));

  ds_geom_counter #(.G_WIDTH(G_WIDTH)) u_geom (
    .clk_i      (clk),
    .rst_n_i    (rst),
    .load_i     (geo_load),
    .adv_i      (adv),
    .width_i    (cfg_width),
    .height_i   (cfg_height),
    .col_end_o  (col_end),
    .line_end_o (line_end),
    .origin_o   (origin)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    up_ready_c = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    adv        = 1'b0;
    geo_load   = 1'b0;
    frame_end  = 1'b0;
    sof_err    = 1'b0;
    eol_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        up_ready_c = 1'b1;
        if (enable && cfg_ok) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        // Geometry follows cfg_* until the SOF beat latches it.
        geo_load   = 1'b1;
        up_ready_c = up_tuser ? pass_ok : 1'b1;
        if (up_valid && up_tuser && pass_ok) begin
          load      = 1'b1;
          load_data = up_data;
          adv       = 1'b1;
          eol_err   = (up_tlast != col_end);
          state_d   = ST_ACTIVE;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Position is never the origin here, so any SOF is premature and is
        // left waiting at the input while the frame is padded out.
        if (up_valid && up_tuser) begin
          sof_err = 1'b1;
          state_d = ST_PAD;
        end else begin
          up_ready_c = pass_ok;
          if (up_valid && pass_ok) begin
            load      = 1'b1;
            load_data = up_data;
            adv       = 1'b1;
            eol_err   = (up_tlast != col_end);
          end
        end
      end
      ST_PAD: begin
        if (pass_ok) begin
          load = 1'b1;
          adv  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv && col_end && line_end) begin
      frame_end = 1'b1;
      state_d   = enable ? ST_WAIT_SOF : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q  <= 1'b0;
      dv_q      <= 1'b0;
      dd_q      <= '0;
      dl_q      <= 1'b0;
      du_q      <= 1'b0;
      fd_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      fd_q      <= frame_end;
      cfg_err_q <= (state_q == ST_IDLE) && enable && !cfg_ok;
      if (load) begin
        dv_q <= 1'b1;
        dd_q <= load_data;
        dl_q <= col_end;
        du_q <= origin;
      end else if (down_ready) begin
        dv_q <= 1'b0;
      end
    end
  end

  // up_ready is held low until the first clock after reset release.
  assign up_ready   = rdy_en_q && up_ready_c;
  assign down_valid = dv_q;
  assign down_data  = dd_q;
  assign down_tlast = dl_q;
  assign down_tuser = du_q;
  assign frame_done = fd_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q == ST_ACTIVE) || (state_q == ST_PAD);

`ifdef DS_FRAME_CTRL_STATUS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [ERR_CNT_W-1:0]   err_sof_q, err_eol_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      err_sof_q   <= '0;
      err_eol_q   <= '0;
    end else begin
      if (frame_end) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (sof_err)   err_sof_q   <= sat_inc(err_sof_q);
      if (eol_err)   err_eol_q   <= sat_inc(err_eol_q);
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign err_sof_cnt = err_sof_q;
  assign err_eol_cnt = err_eol_q;
`else
  logic unused_status;
  assign unused_status = sof_err | eol_err;
  assign frame_cnt     = '0;
  assign err_sof_cnt   = '0;
  assign err_eol_cnt   = '0;
`endif

endmodule

// File: tb/tb_ds_frame_controller.sv
// Testbench for ds_frame_controller: table-driven upstream beats with a
// scoreboard queue of expected downstream beats.
module tb_ds_frame_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  up_data = '0;
  logic        up_valid = 1'b0, up_tlast = 1'b0, up_tuser = 1'b0;
  logic        up_ready;
  logic [7:0]  down_data;
  logic        down_valid, down_tlast, down_tuser;
  logic        down_ready = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] cfg_width = 12'd4, cfg_height = 12'd2;
  logic        busy, frame_done, cfg_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_sof_cnt, err_eol_cnt;

  ds_frame_controller #(.D_WIDTH(8), .G_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_ready(up_ready),
    .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
    .down_tuser(down_tuser), .down_ready(down_ready),
    .enable(enable), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt), .err_sof_cnt(err_sof_cnt), .err_eol_cnt(err_eol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic u; logic l; } beat_t;
  typedef struct packed { logic [7:0] d; logic u; logic l; logic fwd; logic eu; logic el; } vec_t;

  beat_t exp_q[$];
  int    checks = 0, errors = 0, fd_count = 0;
  bit    rdy_mode = 1'b0;
  bit    hold_v = 1'b0;
  logic [10:0] hold_val;

  vec_t t_clean[8];
  vec_t t_junk[11];
  vec_t t_eol[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef DS_FRAME_CTRL_STATUS_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic u, input logic l,
                              input logic fwd, input logic eu, input logic el);
    vec_t v;
    v.d = d; v.u = u; v.l = l; v.fwd = fwd; v.eu = eu; v.el = el;
    return v;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    bit done = 1'b0;
    up_data = d; up_tuser = u; up_tlast = l; up_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      #1;
      if (up_ready) done = 1'b1;
      @(negedge clk);
    end
    up_valid = 1'b0; up_tuser = 1'b0; up_tlast = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout data=%0h actual=stalled required=accepted", d);
    end
  endtask

  task automatic run_vec(input vec_t v);
    beat_t b;
    if (v.fwd) begin
      b.d = v.d; b.u = v.eu; b.l = v.el;
      exp_q.push_back(b);
    end
    send_beat(v.d, v.u, v.l);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_status(input string tag, input int fc, input int es, input int ee);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), st(32'(fc)));
    chk({tag, "_err_sof"},   32'(err_sof_cnt), st(32'(es)));
    chk({tag, "_err_eol"},   32'(err_eol_cnt), st(32'(ee)));
  endtask

  // Downstream ready: always high, or toggling every cycle.
  initial begin
    forever begin
      @(negedge clk);
      down_ready = rdy_mode ? ~down_ready : 1'b1;
    end
  end

  // Scoreboard monitor: a beat is transferred at the next rising edge when
  // valid and ready are both high here.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (frame_done) fd_count++;
      if (hold_v)
        chk("hold_stable", 32'({down_valid, down_data, down_tlast, down_tuser}), 32'(hold_val));
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", down_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data",  32'(down_data),  32'(e.d));
          chk("beat_tuser", 32'(down_tuser), 32'(e.u));
          chk("beat_tlast", 32'(down_tlast), 32'(e.l));
        end
      end
      hold_v   = down_valid && !down_ready;
      hold_val = {down_valid, down_data, down_tlast, down_tuser};
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t pb;
    for (int i = 0; i < 8; i++) begin
      t_clean[i] = mk(8'(8'h10 + i), i == 0, (i % 4) == 3, 1'b1, i == 0, (i % 4) == 3);
      t_eol[i]   = mk(8'(8'h30 + i), i == 0, (i == 2) || ((i % 4) == 3), 1'b1, i == 0, (i % 4) == 3);
    end
    for (int i = 0; i < 3; i++)  t_junk[i] = mk(8'(8'hE0 + i), 1'b0, i == 1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 11; i++)
      t_junk[i] = mk(8'(8'h20 + i - 3), i == 3, ((i - 3) % 4) == 3, 1'b1, i == 3, ((i - 3) % 4) == 3);

    // Reset values
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_down_valid", 32'(down_valid), 0);
    chk("rst_down_data",  32'(down_data), 0);
    chk("rst_down_tlast", 32'(down_tlast), 0);
    chk("rst_down_tuser", 32'(down_tuser), 0);
    chk("rst_up_ready",   32'(up_ready), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_cfg_err",    32'(cfg_err), 0);
    chk_status("rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("up_ready_at_release", 32'(up_ready), 0);
    @(negedge clk);
    #1 chk("up_ready_after_clk", 32'(up_ready), 1);
    @(negedge clk);

    // Clean 4x2 frame
    for (int i = 0; i < 8; i++) begin
      run_vec(t_clean[i]);
      if (i == 3) begin #1 chk("busy_mid_frame", 32'(busy), 1); end
    end
    drain("drain_clean");
    chk("frames_clean", 32'(fd_count), 1);
    chk("busy_after_clean", 32'(busy), 0);
    chk_status("clean", 1, 0, 0);

    // Junk beats ahead of SOF
    for (int i = 0; i < 11; i++) run_vec(t_junk[i]);
    drain("drain_junk");
    chk("frames_junk", 32'(fd_count), 2);
    chk_status("junk", 2, 0, 0);

    // Early tlast at column 2 of line 0
    for (int i = 0; i < 8; i++) run_vec(t_eol[i]);
    drain("drain_eol");
    chk("frames_eol", 32'(fd_count), 3);
    chk_status("eol", 3, 0, 1);

    // New SOF after 5 pixels: pad col 1..3 of line 1, then next frame
    for (int i = 0; i < 5; i++) run_vec(t_clean[i]);
    pb.d = 8'h00; pb.u = 1'b0; pb.l = 1'b0;
    exp_q.push_back(pb);
    exp_q.push_back(pb);
    pb.l = 1'b1;
    exp_q.push_back(pb);
    for (int i = 0; i < 8; i++) run_vec(t_clean[i]);
    drain("drain_sof");
    chk("frames_sof", 32'(fd_count), 5);
    chk_status("sof", 5, 1, 1);

    // Toggling downstream ready, enable dropped mid-frame
    rdy_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) enable = 1'b0;
      run_vec(t_clean[i]);
    end
    drain("drain_toggle");
    rdy_mode = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("frames_toggle", 32'(fd_count), 6);
    chk("busy_after_disable", 32'(busy), 0);
    chk_status("toggle", 6, 1, 1);

    // Invalid width: stays idle, SOF dropped
    cfg_width = 12'd3;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("cfg_err_set", 32'(cfg_err), 1);
    chk("cfg_err_busy", 32'(busy), 0);
    @(negedge clk);
    send_beat(8'h55, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("cfg_err_no_out", 32'(down_valid), 0);
    chk("cfg_err_idle", 32'(busy), 0);
    cfg_width = 12'd4;
    repeat (3) @(negedge clk);
    #1 chk("cfg_err_clear", 32'(cfg_err), 0);
    @(negedge clk);

    // Reset mid-frame, then a fresh frame
    for (int i = 0; i < 3; i++) run_vec(t_clean[i]);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_down_valid", 32'(down_valid), 0);
    chk("mid_rst_down_data",  32'(down_data), 0);
    chk("mid_rst_down_tuser", 32'(down_tuser), 0);
    chk("mid_rst_up_ready",   32'(up_ready), 0);
    chk("mid_rst_busy",       32'(busy), 0);
    chk_status("mid_rst", 0, 0, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(t_clean[i]);
    drain("drain_after_rst");
    chk("frames_after_rst", 32'(fd_count), 7);
    chk_status("after_rst", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
